dma_apb_cfg_seq: RTL and testbench
==================================

Name: dma_apb_cfg_seq

Overview:
APB-master sequencer that programs and launches one DMA channel transfer per accepted command descriptor. It drives the DMA engine's APB configuration port and waits for the transfer-complete interrupt. It then clears that interrupt and returns a one-cycle response. It sits between the system/test controller and the DMA engine's pclken/psel/penable/paddr/pwrite/pwdata/prdata/pslverr/pready port.

Parameters:
CH_NUM, 8, number of DMA channels addressable; cmd_ch width = clog2(CH_NUM)
PCLK_DIV, 1, APB enable divider; pclken asserts once every PCLK_DIV clk cycles (1 = every cycle)
SIZE_W, 16, width of transfer byte count

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-low
cmd_valid  in  1  descriptor valid
cmd_ready  out  1  sequencer can accept descriptor
cmd_ch  in  clog2(CH_NUM)  target channel
cmd_src  in  32  source address
cmd_dst  in  32  destination address
cmd_size  in  SIZE_W  byte count
rsp_valid  out  1  one-cycle completion pulse
rsp_err  out  2  0=OK, 1=APB slave error, 2=timeout
busy  out  1  sequence in progress
dma_int  in  1  DMA interrupt (INT[0])
pclken  out  1  APB clock enable
psel  out  1  APB select
penable  out  1  APB enable
paddr  out  13  APB address
pwrite  out  1  APB write
pwdata  out  32  APB write data
prdata  in  32  APB read data (unused in base config)
pslverr  in  1  APB error
pready  in  1  APB ready

Behaviour:
- Reset (reset=0): state IDLE. cmd_ready=1. rsp_valid=0, rsp_err=0, busy=0. psel=penable=pwrite=0, paddr=0, pwdata=0. Divider counter=0.
- pclken: divider counts 0..PCLK_DIV-1 and pulses at PCLK_DIV-1. For PCLK_DIV=1 it is constant 1 after reset. APB state advances only in cycles with pclken=1.
- Accept: cmd_valid & cmd_ready registers the descriptor. cmd_ready drops the next cycle and stays 0 until rsp_valid.
- Channel base address = cmd_ch<<8.
- Write list, in order:
  - SRC at +0x00 (cmd_src)
  - DST at +0x04 (cmd_dst)
  - SIZE at +0x08 (zero-extended cmd_size)
  - START at +0x0C (data 1)
- States:
  - IDLE -> SETUP on accept.
  - SETUP: psel=1, penable=0 for one pclken cycle, then ACCESS.
  - ACCESS: psel=1, penable=1, held until pready=1 on a pclken cycle.
    - pslverr=1 at completion -> ERR_CLR with err=1.
    - Otherwise the next write goes to SETUP; after START the state goes to WAIT_INT.
  - WAIT_INT: bus idle (psel=0). Exits on dma_int=1 to CLR_SETUP.
  - CLR_SETUP/CLR_ACCESS: write 1 to INT_CLR at +0x10. pslverr here sets err=1.
  - RSP: rsp_valid=1 for one clk, rsp_err latched, cmd_ready=1 the same cycle, -> IDLE.
  - ERR_CLR: skips remaining writes and the wait, performs the INT_CLR write, then RSP.
- Between consecutive writes psel stays 1 (back-to-back SETUP); penable is 0 in every SETUP.
- paddr, pwdata and pwrite are stable from SETUP through ACCESS completion.
- busy=1 in every state except IDLE.
- dma_int already high when entering WAIT_INT: exit on the first cycle.
- dma_int during the write phase is ignored.
- A new cmd_valid while busy is not accepted; the descriptor must be held by the master.
- Asynchronous reset mid-transfer aborts immediately: all outputs go to reset values and no response is issued.

Optional Feature:
DMA_APB_CFG_SEQ_TIMEOUT_EN
- Enabled: 20-bit counter cleared on WAIT_INT entry, incremented each clk in WAIT_INT. At 0xFFFFF the state goes to ERR_CLR with err=2. Counter is also cleared by reset.
- Disabled: WAIT_INT waits indefinitely; rsp_err value 2 is never produced.

Decomposition:
- Package dma_apb_cfg_pkg:
  - register offsets REG_SRC=0x00, REG_DST=0x04, REG_SIZE=0x08, REG_START=0x0C, REG_INT_CLR=0x10, CH_STRIDE_SHIFT=8
  - rsp_err encodings
  - state enum
- Sub-module dma_apb_cfg_pclk_div: pclken divider.

Test Plan:
- PCLK_DIV=1, pready=1, ch=2, src=0x1000, dst=0x2000, size=0x40:
  - APB writes 0x200=0x1000, 0x204=0x2000, 0x208=0x40, 0x20C=1, each 2 cycles.
  - dma_int after 10 cycles -> write 0x210=1 -> rsp_valid with rsp_err=0.
- pready held low 3 cycles in the DST ACCESS -> penable, paddr and pwdata held stable; sequence then continues normally.
- pslverr=1 on the SIZE write -> no START write; INT_CLR write to 0x210; rsp_err=1.
- PCLK_DIV=4 -> pclken pulses every 4th cycle; each APB phase lasts 4 clk; write order unchanged.
- reset asserted during WAIT_INT -> psel=0, busy=0, cmd_ready=1 asynchronously; no rsp_valid; next descriptor runs cleanly.
- With DMA_APB_CFG_SEQ_TIMEOUT_EN defined and dma_int never asserted -> after 0xFFFFF cycles the INT_CLR write occurs and rsp_err=2.

Source files
------------

// File: rtl/dma_apb_cfg_pkg.sv
// Shared definitions for the DMA APB configuration sequencer:
// register map, response codes and the sequencer state encoding.
package dma_apb_cfg_pkg;

    localparam int unsigned APB_AW          = 13;
    localparam int unsigned CH_STRIDE_SHIFT = 8;

    localparam logic [APB_AW-1:0] REG_SRC     = 13'h000;
    localparam logic [APB_AW-1:0] REG_DST     = 13'h004;
    localparam logic [APB_AW-1:0] REG_SIZE    = 13'h008;
    localparam logic [APB_AW-1:0] REG_START   = 13'h00C;
    localparam logic [APB_AW-1:0] REG_INT_CLR = 13'h010;

    typedef enum logic [1:0] {
        RSP_OK      = 2'd0,
        RSP_SLVERR  = 2'd1,
        RSP_TIMEOUT = 2'd2
    } rsp_err_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_WAIT_INT,
        ST_CLR_SETUP,
        ST_CLR_ACCESS,
        ST_ERR_CLR,
        ST_RSP
    } state_e;

    // Offset of the n-th register in the channel programming list.
    function automatic logic [APB_AW-1:0] cfg_offset(input logic [1:0] idx);
        logic [APB_AW-1:0] off;
        case (idx)
            2'd0:    off = REG_SRC;
            2'd1:    off = REG_DST;
            2'd2:    off = REG_SIZE;
            default: off = REG_START;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/dma_apb_cfg_pclk_div.sv
// APB clock-enable generator: pclken pulses once every PCLK_DIV clk cycles
// (held high permanently when PCLK_DIV is 1).
module dma_apb_cfg_pclk_div #(
    parameter int unsigned PCLK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic pclken
);

    localparam int unsigned CNT_W = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PCLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pclken = (cnt_q == CNT_LAST);

endmodule

// File: rtl/dma_apb_cfg_seq.sv
// APB-master sequencer: programs SRC/DST/SIZE/START of one DMA channel, waits for
// its interrupt, clears it and responds. Optional WAIT_INT timeout: DMA_APB_CFG_SEQ_TIMEOUT_EN.
module dma_apb_cfg_seq
    import dma_apb_cfg_pkg::*;
#(
    parameter int unsigned CH_NUM   = 8,
    parameter int unsigned PCLK_DIV = 1,
    parameter int unsigned SIZE_W   = 16,
    localparam int unsigned CH_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CH_W-1:0]   cmd_ch,
    input  logic [31:0]       cmd_src,
    input  logic [31:0]       cmd_dst,
    input  logic [SIZE_W-1:0] cmd_size,
    output logic              rsp_valid,
    output logic [1:0]        rsp_err,
    output logic              busy,
    input  logic              dma_int,
    output logic              pclken,
    output logic              psel,
    output logic              penable,
    output logic [12:0]       paddr,
    output logic              pwrite,
    output logic [31:0]       pwdata,
    input  logic [31:0]       prdata,
    input  logic              pslverr,
    input  logic              pready
);

    state_e              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [1:0]          err_q, err_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [31:0]         src_q, src_d;
    logic [31:0]         dst_q, dst_d;
    logic [SIZE_W-1:0]   size_q, size_d;
    logic [12:0]         paddr_q, paddr_d;
    logic [31:0]         pwdata_q, pwdata_d;

    logic                accept;
    logic                timed_out;
    logic [1:0]          next_idx;
    logic [31:0]         next_wdata;
    logic [12:0]         cmd_base;
    logic [12:0]         ch_base;
    logic                unused_prdata;

    assign unused_prdata = ^prdata;

    dma_apb_cfg_pclk_div #(
        .PCLK_DIV (PCLK_DIV)
    ) u_pclk_div (
        .clk    (clk),
        .reset  (reset),
        .pclken (pclken)
    );

    assign cmd_base   = 13'(cmd_ch) << CH_STRIDE_SHIFT;
    assign ch_base    = 13'(ch_q) << CH_STRIDE_SHIFT;
    assign next_idx   = idx_q + 2'd1;

    always_comb begin
        case (next_idx)
            2'd1:    next_wdata = dst_q;
            2'd2:    next_wdata = 32'(size_q);
            2'd3:    next_wdata = 32'd1;
            default: next_wdata = src_q;
        endcase
    end

`ifdef DMA_APB_CFG_SEQ_TIMEOUT_EN
    localparam logic [19:0] TMO_LAST = 20'hFFFFF;

    logic [19:0] tmo_q, tmo_d;

    // Held at zero outside WAIT_INT, so every entry starts a fresh count.
    always_comb begin
        tmo_d = '0;
        if (state_q == ST_WAIT_INT) begin
            tmo_d = tmo_q + 20'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign timed_out = (tmo_q == TMO_LAST);
`else
    assign timed_out = 1'b0;
`endif

    assign accept = cmd_valid && cmd_ready;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        err_d    = err_q;
        ch_d     = ch_q;
        src_d    = src_q;
        dst_d    = dst_q;
        size_d   = size_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;

        case (state_q)
            ST_IDLE, ST_RSP: begin
                state_d = ST_IDLE;
                if (accept) begin
                    ch_d     = cmd_ch;
                    src_d    = cmd_src;
                    dst_d    = cmd_dst;
                    size_d   = cmd_size;
                    idx_d    = 2'd0;
                    err_d    = RSP_OK;
                    paddr_d  = cmd_base + REG_SRC;
                    pwdata_d = cmd_src;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (pclken) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (pclken && pready) begin
                    if (pslverr) begin
                        err_d   = RSP_SLVERR;
                        state_d = ST_ERR_CLR;
                    end else if (idx_q == 2'd3) begin
                        state_d = ST_WAIT_INT;
                    end else begin
                        idx_d    = next_idx;
                        paddr_d  = ch_base + cfg_offset(next_idx);
                        pwdata_d = next_wdata;
                        state_d  = ST_SETUP;
                    end
                end
            end
            ST_WAIT_INT: begin
                if (dma_int) begin
                    paddr_d  = ch_base + REG_INT_CLR;
                    pwdata_d = 32'd1;
                    state_d  = ST_CLR_SETUP;
                end else if (timed_out) begin
                    err_d   = RSP_TIMEOUT;
                    state_d = ST_ERR_CLR;
                end
            end
            // Error path still clears the channel interrupt before responding.
            ST_ERR_CLR: begin
                paddr_d  = ch_base + REG_INT_CLR;
                pwdata_d = 32'd1;
                state_d  = ST_CLR_SETUP;
            end
            ST_CLR_SETUP: begin
                if (pclken) begin
                    state_d = ST_CLR_ACCESS;
                end
            end
            ST_CLR_ACCESS: begin
                if (pclken && pready) begin
                    if (pslverr) begin
                        err_d = RSP_SLVERR;
                    end
                    state_d = ST_RSP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            err_q    <= RSP_OK;
            ch_q     <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            size_q   <= '0;
            paddr_q  <= '0;
            pwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            ch_q     <= ch_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            size_q   <= size_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
        end
    end

    assign psel      = (state_q == ST_SETUP) || (state_q == ST_ACCESS) ||
                       (state_q == ST_CLR_SETUP) || (state_q == ST_CLR_ACCESS);
    assign penable   = (state_q == ST_ACCESS) || (state_q == ST_CLR_ACCESS);
    assign pwrite    = psel;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_RSP);
    assign rsp_valid = (state_q == ST_RSP);
    assign rsp_err   = err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dma_apb_cfg_seq.sv
// Randomized self-checking bench for dma_apb_cfg_seq: an APB slave responder with
// random wait states/errors and a list-based model of the expected write sequence.
module tb_dma_apb_cfg_seq;

    localparam int CH_NUM   = 8;
    localparam int PCLK_DIV = 4;
    localparam int SIZE_W   = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmdValid;
    logic        cmdReady;
    logic [2:0]  cmdCh;
    logic [31:0] cmdSrc;
    logic [31:0] cmdDst;
    logic [15:0] cmdSize;
    logic        rspValid;
    logic [1:0]  rspErr;
    logic        busy;
    logic        dmaInt;
    logic        pclken;
    logic        psel;
    logic        penable;
    logic [12:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pslverr;
    logic        pready;

    int total = 0;
    int bad   = 0;
    int kCount = 0;

    logic [12:0] expAddr[$];
    logic [31:0] expData[$];
    logic [12:0] obsAddr[$];
    logic [31:0] obsData[$];
    logic [7:0]  errOff  = 8'hFF;
    bit          stallEn = 1'b0;

    dma_apb_cfg_seq #(
        .CH_NUM   (CH_NUM),
        .PCLK_DIV (PCLK_DIV),
        .SIZE_W   (SIZE_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmdValid),
        .cmd_ready (cmdReady),
        .cmd_ch    (cmdCh),
        .cmd_src   (cmdSrc),
        .cmd_dst   (cmdDst),
        .cmd_size  (cmdSize),
        .rsp_valid (rspValid),
        .rsp_err   (rspErr),
        .busy      (busy),
        .dma_int   (dmaInt),
        .pclken    (pclken),
        .psel      (psel),
        .penable   (penable),
        .paddr     (paddr),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pslverr   (pslverr),
        .pready    (pready)
    );

    always #5 clk = ~clk;

    // Clock cycles since reset release; the divider must pulse on every PCLK_DIV-th.
    always @(posedge clk or negedge reset) begin
        if (!reset) kCount = 0;
        else        kCount = kCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: the four programming writes in order, cut short after a faulted
    // one, always followed by the interrupt clear.
    task automatic buildExpected(input logic [2:0] ch, input logic [31:0] src, input logic [31:0] dst,
                                 input logic [15:0] size, input logic [7:0] eOff, output int expErr);
        logic [31:0] vals [4];
        vals[0] = src;
        vals[1] = dst;
        vals[2] = {16'h0, size};
        vals[3] = 32'd1;
        expErr = 0;
        expAddr.delete();
        expData.delete();
        for (int k = 0; k < 4; k++) begin
            expAddr.push_back(13'(ch * 256 + k * 4));
            expData.push_back(vals[k]);
            if (k * 4 == int'(eOff)) begin
                expErr = 1;
                break;
            end
        end
        expAddr.push_back(13'(ch * 256 + 16));
        expData.push_back(32'd1);
        if (eOff == 8'h10) expErr = 1;
    endtask

    // APB slave responder plus protocol monitor, sampled on the falling edge.
    initial begin
        bit          pPsel, pPen, pDone, done;
        logic [12:0] pAddr;
        logic [31:0] pData;
        pPsel = 0; pPen = 0; pDone = 0; pAddr = '0; pData = '0;
        pready  = 1'b1;
        pslverr = 1'b0;
        prdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pPsel = 0; pPen = 0; pDone = 0;
                continue;
            end
            pready  = stallEn ? ($urandom_range(0, 3) != 0) : 1'b1;
            pslverr = psel && penable && (paddr[7:0] == errOff);
            checkOutput("pclken", {31'h0, pclken}, {31'h0, (kCount % PCLK_DIV) == PCLK_DIV - 1});
            if (pPsel && pPen && !pDone)
                checkOutput("access_held", {31'h0, psel && penable}, 32'd1);
            if (psel && penable) begin
                checkOutput("access_after_setup", {31'h0, pPsel && (!pPen || !pDone)}, 32'd1);
                if (pPsel && !pDone) begin
                    checkOutput("hold_paddr", {19'h0, paddr}, {19'h0, pAddr});
                    checkOutput("hold_pwdata", pwdata, pData);
                end
            end
            done = psel && penable && pclken && pready;
            if (done) begin
                checkOutput("pwrite", {31'h0, pwrite}, 32'd1);
                obsAddr.push_back(paddr);
                obsData.push_back(pwdata);
            end
            pPsel = psel; pPen = penable; pDone = done; pAddr = paddr; pData = pwdata;
        end
    end

    task automatic launch(input logic [2:0] ch, input logic [31:0] src, input logic [31:0] dst,
                          input logic [15:0] size);
        for (int i = 0; i < 50 && !cmdReady; i++) @(negedge clk);
        cmdValid = 1'b1;
        cmdCh    = ch;
        cmdSrc   = src;
        cmdDst   = dst;
        cmdSize  = size;
        @(negedge clk);
        cmdValid = 1'b0;
        cmdCh    = 3'($urandom);
        cmdSrc   = $urandom;
        cmdDst   = $urandom;
        cmdSize  = 16'($urandom);
        checkOutput("busy_after_accept", {31'h0, busy}, 32'd1);
        checkOutput("ready_after_accept", {31'h0, cmdReady}, 32'd0);
    endtask

    task automatic applyStimulus(input logic [2:0] ch, input logic [31:0] src, input logic [31:0] dst,
                                 input logic [15:0] size, input logic [7:0] eOff,
                                 input bit earlyInt, input int intDelay);
        int expErr;
        int delay;
        bit gotRsp;
        int n;
        buildExpected(ch, src, dst, size, eOff, expErr);
        obsAddr.delete();
        obsData.delete();
        errOff = eOff;
        dmaInt = earlyInt;
        delay  = intDelay;
        gotRsp = 0;
        launch(ch, src, dst, size);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rspValid) begin
                gotRsp = 1;
                break;
            end
            checkOutput("ready_low_while_busy", {31'h0, cmdReady}, 32'd0);
            if (obsAddr.size() >= 4 && eOff > 8'h0C && !dmaInt) begin
                if (delay == 0) dmaInt = 1'b1;
                else            delay--;
            end
        end
        if (!gotRsp) begin
            checkOutput("rsp_timeout", 32'd0, 32'd1);
        end else begin
            checkOutput("rsp_err", {30'h0, rspErr}, 32'(expErr));
            checkOutput("rsp_ready", {31'h0, cmdReady}, 32'd1);
            checkOutput("n_writes", 32'(obsAddr.size()), 32'(expAddr.size()));
            n = (obsAddr.size() < expAddr.size()) ? obsAddr.size() : expAddr.size();
            for (int i = 0; i < n; i++) begin
                checkOutput("wr_addr", {19'h0, obsAddr[i]}, {19'h0, expAddr[i]});
                checkOutput("wr_data", obsData[i], expData[i]);
            end
        end
        dmaInt = 1'b0;
        @(negedge clk);
        checkOutput("rsp_one_cycle", {31'h0, rspValid}, 32'd0);
        checkOutput("idle_after_rsp", {31'h0, busy}, 32'd0);
    endtask

    task automatic resetInWait();
        errOff  = 8'hFF;
        stallEn = 1'b0;
        dmaInt  = 1'b0;
        obsAddr.delete();
        obsData.delete();
        launch(3'd6, 32'hAAAA_0000, 32'hBBBB_0000, 16'h0100);
        for (int i = 0; i < 500 && obsAddr.size() < 4; i++) @(negedge clk);
        checkOutput("reached_wait_int", 32'(obsAddr.size()), 32'd4);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("abort_psel", {31'h0, psel}, 32'd0);
        checkOutput("abort_penable", {31'h0, penable}, 32'd0);
        checkOutput("abort_busy", {31'h0, busy}, 32'd0);
        checkOutput("abort_ready", {31'h0, cmdReady}, 32'd1);
        checkOutput("abort_rsp", {31'h0, rspValid}, 32'd0);
        checkOutput("abort_paddr", {19'h0, paddr}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("no_rsp_after_abort", {31'h0, rspValid}, 32'd0);
        end
    endtask

    initial begin
        logic [7:0] eOff;
        int r;
        reset    = 1'b0;
        cmdValid = 1'b0;
        cmdCh    = '0;
        cmdSrc   = '0;
        cmdDst   = '0;
        cmdSize  = '0;
        dmaInt   = 1'b0;
        #1;
        checkOutput("rst_ready", {31'h0, cmdReady}, 32'd1);
        checkOutput("rst_busy", {31'h0, busy}, 32'd0);
        checkOutput("rst_rsp_valid", {31'h0, rspValid}, 32'd0);
        checkOutput("rst_rsp_err", {30'h0, rspErr}, 32'd0);
        checkOutput("rst_psel", {31'h0, psel}, 32'd0);
        checkOutput("rst_penable", {31'h0, penable}, 32'd0);
        checkOutput("rst_pwrite", {31'h0, pwrite}, 32'd0);
        checkOutput("rst_paddr", {19'h0, paddr}, 32'd0);
        checkOutput("rst_pwdata", pwdata, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        $display("[TB] basic descriptor on channel 2");
        applyStimulus(3'd2, 32'h1000, 32'h2000, 16'h0040, 8'hFF, 1'b0, 10);
        checkOutput("basic_start_addr", {19'h0, obsAddr[3]}, 32'h20C);
        checkOutput("basic_clr_addr", {19'h0, obsAddr[4]}, 32'h210);

        $display("[TB] slave error on SIZE write");
        applyStimulus(3'd2, 32'h1000, 32'h2000, 16'h0040, 8'h08, 1'b0, 0);

        $display("[TB] wait states and early interrupt");
        stallEn = 1'b1;
        applyStimulus(3'd5, 32'hDEAD_BEEF, 32'hCAFE_F00D, 16'hFFFF, 8'hFF, 1'b1, 0);
        applyStimulus(3'd7, 32'h0123_4567, 32'h89AB_CDEF, 16'h0001, 8'h10, 1'b0, 3);

        $display("[TB] reset during WAIT_INT");
        resetInWait();
        applyStimulus(3'd1, 32'h5555_0000, 32'h6666_0000, 16'h0200, 8'hFF, 1'b0, 2);

        $display("[TB] random descriptors");
        stallEn = 1'b1;
        for (int t = 0; t < 25; t++) begin
            r = $urandom_range(0, 9);
            if (r < 4)       eOff = 8'(r * 4);
            else if (r == 4) eOff = 8'h10;
            else             eOff = 8'hFF;
            applyStimulus(3'($urandom_range(0, CH_NUM - 1)), $urandom, $urandom, 16'($urandom),
                          eOff, 1'($urandom_range(0, 3) == 0), $urandom_range(0, 12));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
